// File: rtl/i2c_tx_pkg.sv
// Shared types for the I2C TX byte serializer.
//   state_e   : serializer FSM states
//   quarter_t : index of the quarter within one SCL period (0..3)
//   Q_LOW0..Q_HIGH1 : named quarter indices; SCL is low in the first two
//                     quarters of a data/ACK bit and high in the last two.
package i2c_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_DATA,
    ST_ACK,
    ST_STOP
  } state_e;

  typedef logic [1:0] quarter_t;

  localparam quarter_t Q_LOW0  = 2'd0;
  localparam quarter_t Q_LOW1  = 2'd1;
  localparam quarter_t Q_HIGH0 = 2'd2;
  localparam quarter_t Q_HIGH1 = 2'd3;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period timebase for the I2C serializer.
// While run_i is high, counts QUARTER clocks per quarter and steps the
// quarter index 0..3 (wrapping 3->0). While run_i is low both counters are
// held at zero, so the first running cycle is always cycle 0 of quarter 0.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   run_i         : count enable
//   tick_o        : high on the last cycle of the current quarter
//   q_o           : current quarter index
module i2c_quarter_tick
  import i2c_tx_pkg::*;
#(
  parameter int QUARTER = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  output logic       tick_o,
  output logic [1:0] q_o
);

  localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  quarter_t      q_q, q_d;

  assign tick_o = run_i && (cnt_q == CW'(QUARTER - 1));
  assign q_o    = q_q;

  always_comb begin
    cnt_d = '0;
    q_d   = Q_LOW0;
    if (run_i) begin
      if (tick_o) begin
        cnt_d = '0;
        q_d   = q_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        q_d   = q_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      q_q   <= Q_LOW0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

endmodule

// File: rtl/i2c_tx_shifter.sv
// I2C TX byte serializer on the read side of the TX FIFO.
// Pops bytes from the FIFO and drives START, eight data bits MSB-first, the
// ACK slot and STOP onto SCL/SDA; the first byte is the address/RW byte.
//   clk_i, rst_ni   : FIFO read clock, asynchronous active-low reset
//   start_i         : level-sampled transaction request (IDLE only)
//   rdata_i,rempty_i: FIFO head word and empty flag
//   rinc_o          : one-cycle FIFO pop (combinational)
//   sda_i           : sampled SDA line (ACK from slave)
//   scl_o, sda_o    : open-drain drives, 1 = release (registered)
//   busy_o, done_o  : transaction in progress / one-cycle end pulse
//   nack_o          : sticky NACK flag, cleared when a start is accepted
module i2c_tx_shifter
  import i2c_tx_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int QUARTER  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [DATASIZE-1:0] rdata_i,
  input  logic                rempty_i,
  output logic                rinc_o,
  input  logic                sda_i,
  output logic                scl_o,
  output logic                sda_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                nack_o
);

  localparam int BW = (DATASIZE > 1) ? $clog2(DATASIZE) : 1;

  state_e              state_q, state_d;
  logic [DATASIZE-1:0] shift_q, shift_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                ack_q, ack_d;
  logic                nack_q, nack_d;
  logic                scl_q, scl_d;
  logic                sda_q, sda_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                run;
  logic                tick;
  logic [1:0]          q;
  quarter_t            q_n;
  logic                q_end;
  logic                enter_q0;

  assign run = (state_q != ST_IDLE) && (state_q != ST_LOAD);

  i2c_quarter_tick #(.QUARTER(QUARTER)) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .run_i  (run),
    .tick_o (tick),
    .q_o    (q)
  );

  // Quarter index seen in the next cycle. Every state change happens either
  // from a non-running state (index already 0) or at the end of q3 (wraps to 0).
  assign q_n      = tick ? (q + 2'd1) : q;
  assign q_end    = tick && (q == Q_HIGH1);
  // First cycle of a data/ACK bit: SCL has just fallen, so SDA is held one
  // more cycle to keep its edge apart from the SCL edge.
  assign enter_q0 = (state_q == ST_LOAD) || q_end;

  assign rinc_o = (state_q == ST_LOAD) && !rempty_i;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    ack_d   = ack_q;
    nack_d  = nack_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !rempty_i) begin
          nack_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (q_end) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!rempty_i) begin
          shift_d = rdata_i;
          bit_d   = BW'(DATASIZE - 1);
          state_d = ST_DATA;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_DATA: begin
        if (q_end) begin
          shift_d = shift_q << 1;
          bit_d   = bit_q - 1'b1;
          if (bit_q == '0) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (tick && (q == Q_HIGH0)) ack_d = sda_i;
        if (q_end) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_STOP: begin
        if (q_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line levels are registered from the next state/quarter so they line up
  // with the state they belong to.
  always_comb begin
    scl_d  = 1'b1;
    sda_d  = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
    case (state_d)
      ST_START: begin
        sda_d = (q_n == Q_LOW0) || (q_n == Q_LOW1);
      end
      ST_LOAD: begin
        scl_d = 1'b0;
        sda_d = sda_q;
      end
      ST_DATA: begin
        scl_d = (q_n >= Q_HIGH0);
        sda_d = enter_q0 ? sda_q : shift_d[DATASIZE-1];
      end
      ST_ACK: begin
        scl_d = (q_n >= Q_HIGH0);
        sda_d = enter_q0 ? sda_q : 1'b1;
      end
      ST_STOP: begin
        scl_d = (q_n >= Q_HIGH0);
        sda_d = (q_n == Q_LOW0) ? sda_q : (q_n == Q_HIGH1);
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign scl_o  = scl_q;
  assign sda_o  = sda_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign nack_o = nack_q;

endmodule

// File: doc/i2c_tx_shifter.md
# i2c_tx_shifter

Byte serializer on the read side of the I2C TX FIFO. It pops bytes from the FIFO and drives START, eight data bits MSB-first, the ACK slot and STOP onto SCL/SDA. The first byte popped is the address/RW byte. It runs in the FIFO read clock domain: `rinc_i`, `rempty_o` and `rdata_o` on the FIFO connect directly to this block's `rinc_o`, `rempty_i` and `rdata_i`.

## Interface
- `DATASIZE`, default 8: FIFO word width and bits per byte.
- `QUARTER`, default 4: clk_i cycles per quarter SCL period; must be ≥2.
- `clk_i` in 1: clock (the FIFO `rclk_i`).
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: level-sampled request to begin a transaction.
- `rdata_i` in DATASIZE: FIFO head word; combinationally valid while `rempty_i`=0.
- `rempty_i` in 1: FIFO empty.
- `rinc_o` out 1: one-cycle pop.
- `sda_i` in 1: sampled SDA line.
- `scl_o` out 1: SCL drive; 1 = release.
- `sda_o` out 1: SDA drive; 1 = release.
- `busy_o` out 1: transaction in progress.
- `done_o` out 1: one-cycle pulse when the transaction ends.
- `nack_o` out 1: sticky; slave NACKed. Cleared when a start is accepted.

## Operation
- **States:** IDLE, START, LOAD, DATA, ACK, STOP.
- **Quarters:** START, DATA (per bit), ACK and STOP each span four quarters, q0–q3, of QUARTER cycles each. LOAD is exactly one cycle.
- **Tick counter:** counts 0..QUARTER-1 in every state except IDLE and LOAD. It is 0 on entry to each quarter.
- **IDLE:** scl=1, sda=1.
  - Start is accepted when `start_i`=1 and `rempty_i`=0.
  - On acceptance: clear `nack_o`, go to START.
  - `start_i` with an empty FIFO, or outside IDLE, is ignored.
- **START:**
  - q0–q1: scl=1, sda=1.
  - q2–q3: scl=1, sda=0.
  - Then go to LOAD.
- **LOAD:** scl=0, sda holds its previous value.
  - If `rempty_i`=0: `rinc_o`=1 this cycle, shift register ← `rdata_i`, bit counter ← DATASIZE-1, go to DATA.
  - If `rempty_i`=1: go to STOP (normal end).
- **DATA:**
  - sda = shift MSB for all four quarters of the bit.
  - q0–q1: scl=0.
  - q2–q3: scl=1.
  - At the end of q3: shift left and decrement the bit counter. After bit 0, go to ACK.
- **ACK:**
  - sda=1 (released).
  - q0–q1: scl=0.
  - q2–q3: scl=1.
  - Sample `sda_i` on the last cycle of q2.
  - At the end of q3: if the sample is 0, go to LOAD. If it is 1, set `nack_o` and go to STOP; remaining FIFO bytes are left unread.
- **STOP:**
  - q0: scl=0, sda holds.
  - q1: scl=0, sda=0.
  - q2: scl=1, sda=0.
  - q3: scl=1, sda=1.
  - Then go to IDLE with `done_o`=1 for one cycle.
- **SDA/SCL ordering:** SDA never changes in the same cycle that SCL changes, except START q2, which is the intended SDA fall while SCL is high.
- **FIFO refill:** bytes written during a transfer are sent in the same transaction if present at LOAD time.
- **Reset assertion** at any time:
  - Immediate return to IDLE.
  - All counters cleared.
  - No pop issued.

## Timing
- **Reset values:** scl_o=1, sda_o=1, rinc_o=0, busy_o=0, done_o=0, nack_o=0.
- **Registered outputs:** `scl_o`, `sda_o`, `busy_o`, `done_o`, `nack_o`.
- **`rinc_o`:** combinational decode of (state==LOAD && !rempty_i). The FIFO pops on the same edge that loads the shift register.
- **Start latency:** start accepted at edge k gives busy_o=1 from cycle k+1. START occupies 4·QUARTER cycles. The first LOAD follows immediately.
- **Per byte:** 1 + 36·QUARTER cycles (LOAD + 8 data bits + ACK).
- **N bytes, all ACKed:** 4Q + N(1+36Q) + 1 + 4Q cycles from acceptance to the `done_o` cycle. busy_o falls in the same cycle that `done_o` rises.
- **Back-to-back start:** a new start may be accepted in the `done_o` cycle.

## Structure
- Shared package `i2c_tx_pkg`:
  - state enum;
  - quarter index type (2 bits);
  - constants `Q_LOW0`..`Q_HIGH1`.
- Sub-module `i2c_quarter_tick`:
  - parameter QUARTER;
  - inputs clk_i, rst_ni, run_i;
  - outputs tick_o (last cycle of a quarter) and q_o (quarter index 0–3, wraps 3→0).
- FSM and shift register live in the top module.

## Test plan
- **Reset:** hold rst_ni=0 with random inputs → scl_o=sda_o=1, rinc_o=busy_o=done_o=nack_o=0.
- **Normal two-byte write:** QUARTER=2, FIFO preloaded 0xA5, 0x3C, sda_i=0 in ACK, start_i pulse →
  - SDA bits 10100101 then 00111100;
  - exactly two rinc_o pulses;
  - done_o 8+2·73+1+8 = 163 cycles after acceptance;
  - nack_o=0.
- **NACK:** FIFO holds 0x80, 0x11; sda_i=1 in the first ACK →
  - one pop only;
  - STOP follows the ACK;
  - nack_o=1;
  - FIFO still not empty with head 0x11.
- **Ignored starts:** start_i with rempty_i=1 → busy_o stays 0. start_i during DATA → no effect on the waveform or byte count.
- **Reset mid-transfer:** rst_ni low during bit 3 of the first byte → same cycle scl_o=sda_o=1 and busy_o=0, no further rinc_o.
- **Refill during transfer:** write 0x5A into the FIFO during byte 2 → sent as byte 3 with no intervening STOP, three pops, done_o once.
